ajuste_horario: RTL

//  Time-setting controller: the write side of the clock counters. Turns raw push-buttons into a

---
 rtl/ajuste_horario.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ajuste_horario.sv
// Time-setting controller: debounced buttons edit a BCD HH:MM snapshot that is strobed into the clock counters.
// Optional hold-to-repeat on inc/dec is compiled in with AUTO_REPEAT_EN.
module ajuste_horario #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 12500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_btn_modo,
  input  logic       i_btn_inc,
  input  logic       i_btn_dec,
  input  logic [1:0] i_cur_h_dez,
  input  logic [3:0] i_cur_h_uni,
  input  logic [2:0] i_cur_m_dez,
  input  logic [3:0] i_cur_m_uni,
  output logic [1:0] o_set_h_dez,
  output logic [3:0] o_set_h_uni,
  output logic [2:0] o_set_m_dez,
  output logic [3:0] o_set_m_uni,
  output logic       o_load,
  output logic       o_editing,
  output logic [5:0] o_blank_mask
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BKW = $clog2(BLINK_DIV + 1);

  typedef enum logic [1:0] {ST_RUN, ST_EDIT_H, ST_EDIT_M} state_t;

  logic [2:0]     w_btn;
  logic [2:0]     r_sync1, r_sync2, r_deb, r_press;
  logic [DBW-1:0] r_db_cnt [3];

  state_t         r_state;
  logic [1:0]     r_h_dez;
  logic [3:0]     r_h_uni;
  logic [2:0]     r_m_dez;
  logic [3:0]     r_m_uni;
  logic           r_load, r_editing, r_phase;
  logic [5:0]     r_mask;
  logic [BKW-1:0] r_blink_cnt;

  logic           w_modo, w_rep_inc, w_rep_dec, w_up, w_dn, w_step_up, w_step_dn;
  logic           w_snap_h_ok, w_snap_m_ok;
  logic [1:0]     w_hi_dez, w_hd_dez;
  logic [3:0]     w_hi_uni, w_hd_uni;
  logic [2:0]     w_mi_dez, w_md_dez;
  logic [3:0]     w_mi_uni, w_md_uni;
  logic [5:0]     w_sel;

  if (DEBOUNCE_CYCLES < 1 || BLINK_DIV < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("ajuste_horario: timing parameters must be >= 1");
  end

  assign w_btn = {i_btn_dec, i_btn_inc, i_btn_modo};

  // Bit order {dec, inc, modo}; r_press pulses on the same edge the debounced level rises.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= DBW'(DEBOUNCE_CYCLES - 1);
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= DBW'(DEBOUNCE_CYCLES - 1);
        end else if (r_db_cnt[i] == '0) begin
          r_db_cnt[i] <= DBW'(DEBOUNCE_CYCLES - 1);
          r_deb[i]    <= r_sync2[i];
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] - DBW'(1);
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);

  logic [RPW-1:0] r_rep_cnt;
  logic           w_hold_up, w_hold_dn, w_rep_run, w_rep_hit;

  assign w_hold_up = r_deb[1] & ~r_deb[2];
  assign w_hold_dn = r_deb[2] & ~r_deb[1];
  assign w_rep_run = (r_state != ST_RUN) & ~w_modo & (w_hold_up | w_hold_dn);
  assign w_rep_hit = w_rep_run & (r_rep_cnt == '0);
  assign w_rep_inc = w_rep_hit & w_hold_up;
  assign w_rep_dec = w_rep_hit & w_hold_dn;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)               r_rep_cnt <= RPW'(REPEAT_DELAY);
    else if (!w_rep_run)       r_rep_cnt <= RPW'(REPEAT_DELAY);
    else if (r_rep_cnt == '0)  r_rep_cnt <= RPW'(REPEAT_RATE - 1);
    else                       r_rep_cnt <= r_rep_cnt - RPW'(1);
  end
`else
  assign w_rep_inc = 1'b0;
  assign w_rep_dec = 1'b0;
`endif

  assign w_modo    = r_press[0];
  assign w_up      = r_press[1] | w_rep_inc;
  assign w_dn      = r_press[2] | w_rep_dec;
  assign w_step_up = w_up & ~w_dn;
  assign w_step_dn = w_dn & ~w_up;
  assign w_sel     = (r_state == ST_EDIT_M) ? 6'b001100 : 6'b110000;

  assign w_snap_h_ok = (i_cur_h_dez == 2'd2) ? (i_cur_h_uni <= 4'd3)
                                             : ((i_cur_h_dez < 2'd2) && (i_cur_h_uni <= 4'd9));
  assign w_snap_m_ok = (i_cur_m_dez <= 3'd5) && (i_cur_m_uni <= 4'd9);

  always_comb begin
    w_hi_dez = r_h_dez;
    w_hi_uni = r_h_uni + 4'd1;
    if (r_h_dez == 2'd2 && r_h_uni == 4'd3) begin
      w_hi_dez = 2'd0;
      w_hi_uni = 4'd0;
    end else if (r_h_uni == 4'd9) begin
      w_hi_dez = r_h_dez + 2'd1;
      w_hi_uni = 4'd0;
    end
    w_hd_dez = r_h_dez;
    w_hd_uni = r_h_uni - 4'd1;
    if (r_h_dez == 2'd0 && r_h_uni == 4'd0) begin
      w_hd_dez = 2'd2;
      w_hd_uni = 4'd3;
    end else if (r_h_uni == 4'd0) begin
      w_hd_dez = r_h_dez - 2'd1;
      w_hd_uni = 4'd9;
    end
    w_mi_dez = r_m_dez;
    w_mi_uni = r_m_uni + 4'd1;
    if (r_m_uni == 4'd9) begin
      w_mi_dez = (r_m_dez == 3'd5) ? 3'd0 : r_m_dez + 3'd1;
      w_mi_uni = 4'd0;
    end
    w_md_dez = r_m_dez;
    w_md_uni = r_m_uni - 4'd1;
    if (r_m_uni == 4'd0) begin
      w_md_dez = (r_m_dez == 3'd0) ? 3'd5 : r_m_dez - 3'd1;
      w_md_uni = 4'd9;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_h_dez     <= '0;
      r_h_uni     <= '0;
      r_m_dez     <= '0;
      r_m_uni     <= '0;
      r_load      <= 1'b0;
      r_editing   <= 1'b0;
      r_phase     <= 1'b0;
      r_mask      <= '0;
      r_blink_cnt <= BKW'(BLINK_DIV - 1);
    end else begin
      r_load <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_modo) begin
            r_state   <= ST_EDIT_H;
            r_editing <= 1'b1;
            r_h_dez   <= w_snap_h_ok ? i_cur_h_dez : 2'd0;
            r_h_uni   <= w_snap_h_ok ? i_cur_h_uni : 4'd0;
            r_m_dez   <= w_snap_m_ok ? i_cur_m_dez : 3'd0;
            r_m_uni   <= w_snap_m_ok ? i_cur_m_uni : 4'd0;
          end
        end
        ST_EDIT_H: begin
          if (w_modo) begin
            r_state <= ST_EDIT_M;
          end else if (w_step_up) begin
            r_h_dez <= w_hi_dez;
            r_h_uni <= w_hi_uni;
          end else if (w_step_dn) begin
            r_h_dez <= w_hd_dez;
            r_h_uni <= w_hd_uni;
          end
        end
        ST_EDIT_M: begin
          if (w_modo) begin
            r_state   <= ST_RUN;
            r_load    <= 1'b1;
            r_editing <= 1'b0;
          end else if (w_step_up) begin
            r_m_dez <= w_mi_dez;
            r_m_uni <= w_mi_uni;
          end else if (w_step_dn) begin
            r_m_dez <= w_md_dez;
            r_m_uni <= w_md_uni;
          end
        end
        default: r_state <= ST_RUN;
      endcase

      // Mask follows the new phase on the same edge so the blink never lags a state change.
      if (r_state == ST_RUN || w_modo || w_step_up || w_step_dn) begin
        r_blink_cnt <= BKW'(BLINK_DIV - 1);
        r_phase     <= 1'b0;
        r_mask      <= '0;
      end else if (r_blink_cnt == '0) begin
        r_blink_cnt <= BKW'(BLINK_DIV - 1);
        r_phase     <= ~r_phase;
        r_mask      <= r_phase ? 6'b000000 : w_sel;
      end else begin
        r_blink_cnt <= r_blink_cnt - BKW'(1);
      end
    end
  end

  assign o_set_h_dez  = r_h_dez;
  assign o_set_h_uni  = r_h_uni;
  assign o_set_m_dez  = r_m_dez;
  assign o_set_m_uni  = r_m_uni;
  assign o_load       = r_load;
  assign o_editing    = r_editing;
  assign o_blank_mask = r_mask;

endmodule
